// File: rtl/int_sequencer_if.sv
// Bus between the interrupt/reset sequencer, memory read data, the control FSM and the datapath.
// The master modport is the sequencer's view; the slave modport is the surrounding core's view.
interface int_sequencer_if;
  logic [7:0]  mem_data;
  logic        last_cycle;
  logic        p_i;
  logic        nmi_n;
  logic        irq_n;
  logic        vec_ack;
  logic [7:0]  data_out;
  logic        int_active;
  logic [15:0] vec_addr;
  logic        b_flag;
  logic        pc_inc_inhibit;
  logic        push_inhibit;

  modport master (
    input  mem_data, last_cycle, p_i, nmi_n, irq_n, vec_ack,
    output data_out, int_active, vec_addr, b_flag, pc_inc_inhibit, push_inhibit
  );

  modport slave (
    output mem_data, last_cycle, p_i, nmi_n, irq_n, vec_ack,
    input  data_out, int_active, vec_addr, b_flag, pc_inc_inhibit, push_inhibit
  );
endinterface

// File: rtl/int_sequencer.sv
// Interrupt/reset sequencer: substitutes BRK at instruction boundaries when reset, NMI or IRQ is
// pending, and supplies the vector address and hardware-entry flags to the datapath.
module int_sequencer #(
  parameter logic [7:0] BRK_OPCODE  = 8'h00,
  parameter int         SYNC_STAGES = 2
) (
  input logic            ph2,
  input logic            reset,
  int_sequencer_if.master bus
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("int_sequencer: SYNC_STAGES must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_INJECT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_RESET = 2'd1,
    SRC_NMI   = 2'd2,
    SRC_IRQ   = 2'd3
  } src_e;

  logic [SYNC_STAGES-1:0] nmi_sync_q, nmi_sync_d;
  logic [SYNC_STAGES-1:0] irq_sync_q, irq_sync_d;
  logic                   nmi_prev_q, nmi_prev_d;
  logic                   nmi_pend_q, nmi_pend_d;
  state_e                 state_q, state_d;
  src_e                   src_q, src_d;

  logic nmi_s;
  logic irq_s;
  logic nmi_edge;
  logic nmi_taken;
  logic irq_req;

  logic [7:0]  data_out_c;
  logic        int_active_c;
  logic [15:0] vec_addr_c;
  logic        b_flag_c;
  logic        pc_inc_inhibit_c;
  logic        push_inhibit_c;

  // Pin synchronizers, NMI falling-edge detect and the sticky NMI request.
  always_comb begin
    nmi_sync_d = {nmi_sync_q[SYNC_STAGES-2:0], bus.nmi_n};
    irq_sync_d = {irq_sync_q[SYNC_STAGES-2:0], bus.irq_n};
    nmi_s      = nmi_sync_q[SYNC_STAGES-1];
    irq_s      = irq_sync_q[SYNC_STAGES-1];
    nmi_prev_d = nmi_s;
    nmi_edge   = nmi_prev_q & ~nmi_s;
    nmi_taken  = (state_q == ST_INJECT) && (src_q == SRC_NMI);
    // A fresh edge wins over the clear so an NMI arriving during its own injection is not lost.
    nmi_pend_d = (nmi_pend_q & ~nmi_taken) | nmi_edge;
    irq_req    = ~irq_s & ~bus.p_i;
  end

  always_ff @(posedge ph2 or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_INJECT;
      src_q      <= SRC_RESET;
      nmi_pend_q <= 1'b0;
      nmi_prev_q <= 1'b1;
      nmi_sync_q <= '1;
      irq_sync_q <= '1;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      nmi_pend_q <= nmi_pend_d;
      nmi_prev_q <= nmi_prev_d;
      nmi_sync_q <= nmi_sync_d;
      irq_sync_q <= irq_sync_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.last_cycle && (nmi_pend_q || irq_req)) begin
          state_d = ST_INJECT;
          src_d   = nmi_pend_q ? SRC_NMI : SRC_IRQ;
        end
      end
      ST_INJECT: begin
        state_d = ST_SERVICE;
      end
      ST_SERVICE: begin
        // Boundaries are ignored here; only the vector load ends the entry.
        if (bus.vec_ack) begin
          state_d = ST_IDLE;
          src_d   = SRC_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        src_d   = SRC_NONE;
      end
    endcase
  end

  always_comb begin
    data_out_c       = bus.mem_data;
    int_active_c     = 1'b0;
    pc_inc_inhibit_c = 1'b0;
    unique case (state_q)
      ST_INJECT: begin
        data_out_c       = BRK_OPCODE;
        int_active_c     = 1'b1;
        pc_inc_inhibit_c = 1'b1;
      end
      ST_SERVICE: begin
        int_active_c = 1'b1;
      end
      default: begin
        data_out_c = bus.mem_data;
      end
    endcase

    push_inhibit_c = (src_q == SRC_RESET);
    b_flag_c       = (src_q == SRC_NONE);
    unique case (src_q)
      SRC_RESET: vec_addr_c = 16'hFFFC;
      SRC_NMI:   vec_addr_c = 16'hFFFA;
      default:   vec_addr_c = 16'hFFFE;
    endcase
  end

  assign bus.data_out       = data_out_c;
  assign bus.int_active     = int_active_c;
  assign bus.vec_addr       = vec_addr_c;
  assign bus.b_flag         = b_flag_c;
  assign bus.pc_inc_inhibit = pc_inc_inhibit_c;
  assign bus.push_inhibit   = push_inhibit_c;

endmodule

// File: tb/tb_int_sequencer.sv
// Bench for int_sequencer: directed vector table, hand-written corner sequences and a randomized
// run against a behavioural model of the entry rules.
module tb_int_sequencer;
  localparam int S = 2;

  logic ph2   = 1'b0;
  logic reset = 1'b1;

  int_sequencer_if bus();

  int_sequencer #(.BRK_OPCODE(8'h00), .SYNC_STAGES(S)) dut (
    .ph2  (ph2),
    .reset(reset),
    .bus  (bus)
  );

  always #5 ph2 = ~ph2;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic [7:0]  md;
    logic        lc, pi, irq, nmi, ack;
    logic [7:0]  e_d;
    logic        e_ia;
    logic [15:0] e_va;
    logic        e_b, e_pci, e_pu;
  } vec_t;

  vec_t tbl[15];

  // Behavioural model: source of the current entry (0 none, 1 reset, 2 NMI, 3 IRQ),
  // whether this is its opcode cycle, the pending NMI, and the pin sample histories.
  localparam logic [15:0] VEC [4] = '{16'hFFFE, 16'hFFFC, 16'hFFFA, 16'hFFFE};
  int   m_src;
  bit   m_opc;
  bit   m_pend;
  logic nh[S+1];
  logic ih[S];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] d, input logic ia,
                         input logic [15:0] va, input logic b, input logic pci, input logic pu);
    chk({tag, "/data_out"},       {8'h00, bus.data_out},        {8'h00, d});
    chk({tag, "/int_active"},     {15'h0, bus.int_active},      {15'h0, ia});
    chk({tag, "/vec_addr"},       bus.vec_addr,                 va);
    chk({tag, "/b_flag"},         {15'h0, bus.b_flag},          {15'h0, b});
    chk({tag, "/pc_inc_inhibit"}, {15'h0, bus.pc_inc_inhibit},  {15'h0, pci});
    chk({tag, "/push_inhibit"},   {15'h0, bus.push_inhibit},    {15'h0, pu});
  endtask

  task automatic cyc();
    @(posedge ph2);
    #1;
  endtask

  task automatic nmi_pulse();
    bus.nmi_n = 1'b0;
    cyc();
    bus.nmi_n = 1'b1;
  endtask

  task automatic model_reset();
    m_src  = 1;
    m_opc  = 1'b1;
    m_pend = 1'b0;
    for (int k = 0; k <= S; k++) nh[k] = 1'b1;
    for (int k = 0; k < S; k++)  ih[k] = 1'b1;
  endtask

  task automatic model_step();
    bit edge_seen;
    bit new_pend;
    if (!reset) begin
      model_reset();
      return;
    end
    edge_seen = !nh[S-1] && nh[S];
    new_pend  = (m_pend && !(m_opc && m_src == 2)) || edge_seen;
    if (m_src == 0) begin
      if (bus.last_cycle && (m_pend || (!ih[S-1] && !bus.p_i))) begin
        m_src = m_pend ? 2 : 3;
        m_opc = 1'b1;
      end
    end else if (m_opc) begin
      m_opc = 1'b0;
    end else if (bus.vec_ack) begin
      m_src = 0;
    end
    m_pend = new_pend;
    for (int k = S; k > 0; k--) nh[k] = nh[k-1];
    nh[0] = bus.nmi_n;
    for (int k = S - 1; k > 0; k--) ih[k] = ih[k-1];
    ih[0] = bus.irq_n;
  endtask

  task automatic model_check(input string tag);
    chk_all(tag, m_opc ? 8'h00 : bus.mem_data, m_src != 0, VEC[m_src],
            m_src == 0, m_opc, m_src == 1);
  endtask

  initial begin
    bus.mem_data   = 8'hA9;
    bus.last_cycle = 1'b0;
    bus.p_i        = 1'b1;
    bus.irq_n      = 1'b1;
    bus.nmi_n      = 1'b1;
    bus.vec_ack    = 1'b0;
    #1;

    //          rst   md     lc    pi    irq   nmi   ack    d      ia    va         b     pci   pu
    tbl[0]  = '{1'b0, 8'hA9, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 16'hFFFC, 1'b0, 1'b1, 1'b1};
    tbl[1]  = '{1'b0, 8'hA9, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 16'hFFFC, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 8'hA9, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 16'hFFFC, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 8'hA9, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA9, 1'b1, 16'hFFFC, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 8'hA9, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA9, 1'b1, 16'hFFFC, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 8'hA9, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA9, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 8'hA9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA9, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 8'hA9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA9, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 8'hA9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA9, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 8'hA9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA9, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 8'hA9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'hFFFE, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 8'hA9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA9, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 8'hA9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA9, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 15; i++) begin
      reset          = tbl[i].rst;
      bus.mem_data   = tbl[i].md;
      bus.last_cycle = tbl[i].lc;
      bus.p_i        = tbl[i].pi;
      bus.irq_n      = tbl[i].irq;
      bus.nmi_n      = tbl[i].nmi;
      bus.vec_ack    = tbl[i].ack;
      cyc();
      chk_all($sformatf("tbl%0d", i), tbl[i].e_d, tbl[i].e_ia, tbl[i].e_va,
              tbl[i].e_b, tbl[i].e_pci, tbl[i].e_pu);
    end

    // NMI edge held pending until the first boundary, then taken once only.
    bus.mem_data   = 8'hEA;
    bus.last_cycle = 1'b0;
    nmi_pulse();
    repeat (9) cyc();
    bus.last_cycle = 1'b1;
    cyc();
    chk_all("nmi_take", 8'h00, 1'b1, 16'hFFFA, 1'b0, 1'b1, 1'b0);
    bus.last_cycle = 1'b0;
    cyc();
    chk({"nmi_service/int_active"}, {15'h0, bus.int_active}, 16'h0001);
    bus.vec_ack = 1'b1;
    cyc();
    bus.vec_ack = 1'b0;
    bus.last_cycle = 1'b1;
    cyc();
    chk_all("nmi_no_second", 8'hEA, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0);
    bus.last_cycle = 1'b0;

    // NMI and IRQ at the same boundary: NMI first, IRQ at the following boundary.
    bus.irq_n = 1'b0;
    bus.p_i   = 1'b0;
    nmi_pulse();
    repeat (5) cyc();
    bus.last_cycle = 1'b1;
    cyc();
    chk_all("prio_nmi", 8'h00, 1'b1, 16'hFFFA, 1'b0, 1'b1, 1'b0);
    bus.last_cycle = 1'b0;
    cyc();
    bus.vec_ack = 1'b1;
    cyc();
    bus.vec_ack = 1'b0;
    bus.last_cycle = 1'b1;
    cyc();
    chk_all("prio_irq", 8'h00, 1'b1, 16'hFFFE, 1'b0, 1'b1, 1'b0);
    bus.last_cycle = 1'b0;
    cyc();
    bus.vec_ack = 1'b1;
    cyc();
    bus.vec_ack = 1'b0;

    // NMI arriving while an IRQ is being serviced waits for the return to IDLE.
    bus.last_cycle = 1'b1;
    cyc();
    chk_all("svc_irq", 8'h00, 1'b1, 16'hFFFE, 1'b0, 1'b1, 1'b0);
    bus.last_cycle = 1'b0;
    bus.irq_n = 1'b1;
    cyc();
    nmi_pulse();
    bus.last_cycle = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk_all($sformatf("svc_hold%0d", k), 8'hEA, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    end
    bus.last_cycle = 1'b0;
    bus.vec_ack = 1'b1;
    cyc();
    bus.vec_ack = 1'b0;
    chk({"svc_exit/int_active"}, {15'h0, bus.int_active}, 16'h0000);
    bus.last_cycle = 1'b1;
    cyc();
    chk_all("svc_nmi", 8'h00, 1'b1, 16'hFFFA, 1'b0, 1'b1, 1'b0);
    bus.last_cycle = 1'b0;
    cyc();

    // Reset during NMI service with a second NMI pending discards the pending NMI.
    nmi_pulse();
    repeat (4) cyc();
    reset = 1'b0;
    #1;
    chk_all("rst_mid", 8'h00, 1'b1, 16'hFFFC, 1'b0, 1'b1, 1'b1);
    cyc();
    reset = 1'b1;
    cyc();
    bus.vec_ack = 1'b1;
    cyc();
    bus.vec_ack = 1'b0;
    bus.last_cycle = 1'b1;
    cyc();
    chk_all("rst_pend_gone", 8'hEA, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0);
    bus.last_cycle = 1'b0;

    // Randomized run against the model.
    reset = 1'b0;
    #1;
    model_reset();
    model_check("rnd_init");
    @(posedge ph2);
    model_step();
    #1;
    model_check("rnd_init_edge");
    reset = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bus.mem_data   = 8'($urandom);
      bus.last_cycle = ($urandom_range(0, 2) == 0);
      bus.p_i        = 1'($urandom_range(0, 1));
      bus.irq_n      = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) bus.nmi_n = ~bus.nmi_n;
      bus.vec_ack    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        #1;
        model_reset();
        model_check($sformatf("rnd_async%0d", i));
      end else begin
        reset = 1'b1;
      end
      @(posedge ph2);
      model_step();
      #1;
      model_check($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
